perf_counter_bank: RTL and testbench

Synthesizable performance-event counter bank for the pipelined CPU, replacing bench-side stall/flush tallies with on-chip counters. Counts NUM_CH independent event strobes (stall, flush, retire, branch-taken, …) plus a free-running cycle count. Counting can be gated, cleared, snapshotted and auto-stopped at a programmable cycle limit. Sits beside the CPU top level and is fed from HazardDetection, IF_ID flush and WB-stage signals.

---
 rtl/perf_pkg.sv | 20 ++
 rtl/perf_sat_counter.sv | 58 +++++
 rtl/perf_counter_bank.sv | 125 ++++++++++++
 tb/tb_perf_counter_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
// No logic; no latency.
// No flow control.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 32;

    localparam int CH_STALL  = 0;
    localparam int CH_FLUSH  = 1;
    localparam int CH_RETIRE = 2;
    localparam int CH_BRANCH = 3;

endpackage

// File: rtl/perf_sat_counter.sv
// One saturating event counter with sticky overflow flag and shadow register.
// Count visible one edge after the enabled event.
// No backpressure; an event while saturated only sets the overflow flag.
module perf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             snap_i,
    input  logic             en_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] shadow_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             ovf_q, ovf_d;

    // Shadow captures the pre-edge count, so a snap on a clearing edge still keeps the old value.
    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        shadow_d = shadow_q;
        if (snap_i) begin
            shadow_d = cnt_q;
        end
        if (clear_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_i && inc_i) begin
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            shadow_q <= shadow_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign shadow_o = shadow_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters plus a cycle counter, with run/pause/limit FSM.
// Internal counts 1 edge after the event; read ports add one more edge.
// No backpressure; counters saturate and flag overflow.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [NUM_CH-1:0] event_i,
    input  logic              clear_i,
    input  logic              snap_i,
    input  logic [CNT_W-1:0]  limit_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [CNT_W-1:0]  rd_live_o,
    output logic [CNT_W-1:0]  rd_snap_o,
    output logic [CNT_W-1:0]  cycle_o,
    output logic [NUM_CH-1:0] ovf_o,
    output logic              done_o,
    output logic              snap_valid_o
);

    state_t           state_q, state_d;
    logic             snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0] rd_live_q, rd_live_d;
    logic [CNT_W-1:0] rd_snap_q, rd_snap_d;

    logic [CNT_W-1:0] live_cnt   [NUM_CH];
    logic [CNT_W-1:0] shadow_cnt [NUM_CH];
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] cycle_shadow_unused;
    logic             cycle_ovf_unused;
    logic             run_en;
    logic             limit_hit;

    assign run_en = (state_q == RUN);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        perf_sat_counter #(.CNT_W(CNT_W)) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clear_i  (clear_i),
            .snap_i   (snap_i),
            .en_i     (run_en),
            .inc_i    (event_i[k]),
            .cnt_o    (live_cnt[k]),
            .shadow_o (shadow_cnt[k]),
            .ovf_o    (ovf_o[k])
        );
    end

    perf_sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear_i),
        .snap_i   (snap_i),
        .en_i     (run_en),
        .inc_i    (1'b1),
        .cnt_o    (cycle_cnt),
        .shadow_o (cycle_shadow_unused),
        .ovf_o    (cycle_ovf_unused)
    );

    // DONE is entered on the edge that brings the cycle count up to the limit.
    assign limit_hit = run_en && (limit_i != '0) && (cycle_cnt != '1)
                       && ((cycle_cnt + CNT_W'(1)) == limit_i);

    always_comb begin
        state_d      = state_q;
        snap_valid_d = snap_valid_q;
        if (snap_i) begin
            snap_valid_d = 1'b1;
        end
        if (clear_i) begin
            state_d      = IDLE;
            snap_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE:    if (start_i) state_d = RUN;
                RUN: begin
                    if (limit_hit)     state_d = DONE;
                    else if (!start_i) state_d = IDLE;
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_live_d = '0;
        rd_snap_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_i == SEL_W'(k)) begin
                rd_live_d = live_cnt[k];
                rd_snap_d = shadow_cnt[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            snap_valid_q <= 1'b0;
            rd_live_q    <= '0;
            rd_snap_q    <= '0;
        end else begin
            state_q      <= state_d;
            snap_valid_q <= snap_valid_d;
            rd_live_q    <= rd_live_d;
            rd_snap_q    <= rd_snap_d;
        end
    end

    assign rd_live_o    = rd_live_q;
    assign rd_snap_o    = rd_snap_q;
    assign cycle_o      = cycle_cnt;
    assign done_o       = (state_q == DONE);
    assign snap_valid_o = snap_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a 32-bit bank and a 4-bit bank for saturation.
module tb_perf_counter_bank;
    import perf_pkg::*;

    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int WS  = 4;
    localparam int SW  = 2;

    logic clk_i = 1'b0;
    logic rst_i;

    logic           start, clear, snap;
    logic [NCH-1:0] ev;
    logic [W-1:0]   limit;
    logic [SW-1:0]  sel;
    logic [W-1:0]   rd_live, rd_snap, cycle;
    logic [NCH-1:0] ovf;
    logic           done, snap_valid;

    logic           b_start, b_clear, b_snap;
    logic [NCH-1:0] b_ev;
    logic [WS-1:0]  b_limit;
    logic [SW-1:0]  b_sel;
    logic [WS-1:0]  b_rd_live, b_rd_snap, b_cycle;
    logic [NCH-1:0] b_ovf;
    logic           b_done, b_snap_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start), .event_i(ev),
        .clear_i(clear), .snap_i(snap), .limit_i(limit), .sel_i(sel),
        .rd_live_o(rd_live), .rd_snap_o(rd_snap), .cycle_o(cycle),
        .ovf_o(ovf), .done_o(done), .snap_valid_o(snap_valid)
    );

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(WS)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(b_start), .event_i(b_ev),
        .clear_i(b_clear), .snap_i(b_snap), .limit_i(b_limit), .sel_i(b_sel),
        .rd_live_o(b_rd_live), .rd_snap_o(b_rd_snap), .cycle_o(b_cycle),
        .ovf_o(b_ovf), .done_o(b_done), .snap_valid_o(b_snap_valid)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        start = 0; clear = 0; snap = 0; ev = '0; limit = '0; sel = '0;
        b_start = 0; b_clear = 0; b_snap = 0; b_ev = '0; b_limit = '0; b_sel = '0;
        tick(); tick();
        rst_i = 1'b0;

        chk("reset_rd_live", rd_live, 0);
        chk("reset_rd_snap", rd_snap, 0);
        chk("reset_cycle", cycle, 0);
        chk("reset_ovf", 32'(ovf), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_snap_valid", 32'(snap_valid), 0);
        chk("reset_state", 32'(dut.state_q), 32'(IDLE));

        // Reset mid-RUN with ch0=7, ch1=3
        start = 1; tick();
        for (int i = 0; i < 7; i++) begin
            ev = (i < 3) ? 4'b0011 : 4'b0001;
            tick();
        end
        chk("midrun_cycle", cycle, 7);
        ev = '0; start = 0; sel = 0; tick();
        chk("midrun_ch0", rd_live, 7);
        chk("midrun_cycle_stop", cycle, 8);
        sel = 1; tick();
        chk("midrun_ch1", rd_live, 3);
        rst_i = 1; tick(); rst_i = 0;
        chk("rst_rd_live", rd_live, 0);
        chk("rst_cycle", cycle, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        start = 1; ev = 4'b0001; sel = 0;
        tick();
        tick();
        start = 0; ev = '0; tick();
        tick();
        chk("resume_cycle", cycle, 2);
        chk("resume_ch0", rd_live, 1);
        clear = 1; tick(); clear = 0;

        // Cycle limit of 10
        limit = 10; start = 1; ev = 4'b0001; sel = 0;
        tick();
        for (int i = 0; i < 9; i++) tick();
        chk("limit_cycle9", cycle, 9);
        chk("limit_done9", 32'(done), 0);
        tick();
        chk("limit_cycle10", cycle, 10);
        chk("limit_done10", 32'(done), 1);
        tick(); tick(); tick();
        chk("limit_frozen_cycle", cycle, 10);
        chk("limit_frozen_ch0", rd_live, 10);
        start = 0; tick();
        chk("limit_start_ignored", 32'(done), 1);
        clear = 1; tick(); clear = 0;
        chk("limit_clear_done", 32'(done), 0);
        chk("limit_clear_cycle", cycle, 0);
        limit = 0; ev = '0;

        // Saturation on the 4-bit bank
        b_start = 1; b_ev = 4'b0010; tick();
        for (int i = 0; i < 20; i++) tick();
        b_start = 0; b_ev = '0; b_sel = 1; tick();
        chk("sat_ch1", 32'(b_rd_live), 15);
        chk("sat_ovf", 32'(b_ovf), 32'h2);
        chk("sat_cycle", 32'(b_cycle), 15);
        b_sel = 0; tick();
        chk("sat_ch0", 32'(b_rd_live), 0);
        b_clear = 1; tick(); b_clear = 0;
        chk("sat_clear_ovf", 32'(b_ovf), 0);
        b_sel = 1; tick();
        chk("sat_clear_ch1", 32'(b_rd_live), 0);

        // Snap and clear on the same edge with ch2 at 5
        start = 1; tick();
        ev = 4'b0100;
        for (int i = 0; i < 5; i++) tick();
        snap = 1; clear = 1; tick();
        snap = 0; clear = 0; ev = '0; start = 0; sel = 2; tick();
        chk("snapclr_rd_snap", rd_snap, 5);
        chk("snapclr_rd_live", rd_live, 0);
        chk("snapclr_valid", 32'(snap_valid), 0);
        chk("snapclr_cycle", cycle, 0);
        tick();
        chk("snapclr_retained", rd_snap, 5);
        snap = 1; tick(); snap = 0;
        chk("snap_valid_set", 32'(snap_valid), 1);
        tick();
        chk("snap_new_value", rd_snap, 0);
        clear = 1; tick(); clear = 0;

        // Pause and resume: 4 on, 3 off, 4 on
        start = 1; ev = 4'b0001; sel = 0;
        for (int i = 0; i < 4; i++) tick();
        start = 0; tick();
        chk("gap_state", 32'(dut.state_q), 32'(IDLE));
        chk("gap_cycle_a", cycle, 4);
        tick(); tick();
        chk("gap_cycle_b", cycle, 4);
        start = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("gap_cycle_c", cycle, 7);
        start = 0; tick();
        chk("gap_cycle_end", cycle, 8);
        ev = '0; tick();
        chk("gap_ch0", rd_live, 8);
        clear = 1; tick(); clear = 0;

        // Select sweep over distinct counts 1..4
        start = 1; tick();
        ev = 4'b1111; tick();
        ev = 4'b1110; tick();
        ev = 4'b1100; tick();
        ev = 4'b1000; tick();
        ev = '0; start = 0; tick();
        sel = 3; tick();
        chk("sweep_init", rd_live, 4);
        for (int k = 0; k < NCH; k++) begin
            logic [31:0] prev;
            prev = (k == 0) ? 32'd4 : 32'(k);
            sel = SW'(k);
            #2;
            chk("sweep_hold", rd_live, prev);
            tick();
            chk("sweep_sel", rd_live, 32'(k + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
